// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 control unit: FSM states, opcodes and the
// encoded control-field values driven onto the datapath.
package lc3_pkg;

  typedef enum logic [3:0] {
    FETCH0,
    FETCH1,
    FETCH2,
    DECODE,
    ALU,
    BR,
    JMP,
    LEA,
    ADDR,
    MEMRD,
    LDWB,
    STDATA,
    MEMWR,
    HALT
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOT  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_INC   = 2'b00,
    PC_ADDER = 2'b01,
    PC_BUS   = 2'b10
  } sel_pc_t;

  typedef enum logic [1:0] {
    EAB2_ZERO  = 2'b00,
    EAB2_OFF6  = 2'b01,
    EAB2_OFF9  = 2'b10,
    EAB2_OFF11 = 2'b11
  } sel_eab2_t;

  typedef enum logic [1:0] {
    HC_RUN     = 2'b00,
    HC_TRAP    = 2'b01,
    HC_ILLEGAL = 2'b10,
    HC_TIMEOUT = 2'b11
  } halt_t;

  // Bit positions inside en_bus {enaMARM,enaPC,enaALU,enaMDR} and ld {ldPC,ldIR,ldMAR,ldMDR}
  localparam int unsigned EN_MARM = 3;
  localparam int unsigned EN_PC   = 2;
  localparam int unsigned EN_ALU  = 1;
  localparam int unsigned EN_MDR  = 0;
  localparam int unsigned LD_PC   = 3;
  localparam int unsigned LD_IR   = 2;
  localparam int unsigned LD_MAR  = 1;
  localparam int unsigned LD_MDR  = 0;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR);
  endfunction

  function automatic logic uses_base_reg(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

  function automatic alu_op_t alu_op_of(input logic [3:0] op);
    alu_op_t r;
    case (op)
      OP_ADD:  r = ALU_ADD;
      OP_AND:  r = ALU_AND;
      OP_NOT:  r = ALU_NOT;
      default: r = ALU_PASS;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lc3_mem_wait.sv
// Memory wait-cycle counter: counts unanswered cycles of one access and
// flags a timeout once MEM_WAIT_MAX wait cycles have elapsed without ready.
module lc3_mem_wait
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int unsigned CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_WAIT_MAX);

  logic [CW-1:0] count;

  // Held at zero outside access states; no access state follows another
  // directly, so this is equivalent to clearing on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!active || mem_ready) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CW'(1);
    end
  end

  assign timeout = active && !mem_ready && (count == LIMIT);

endmodule

// File: rtl/lc3_controller.sv
// LC-3 multicycle control unit: fetch/decode/execute FSM driving the
// datapath control fields, with memory-wait timeout and halt status.
module lc3_controller
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic [2:0]  nzp,
  input  logic        mem_ready,
  output logic [1:0]  aluControl,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [2:0]  DR,
  output logic        logicWE,
  output logic        flagWE,
  output logic [1:0]  selPC,
  output logic        selMAR,
  output logic        selEAB1,
  output logic        selMDR,
  output logic [1:0]  selEAB2,
  output logic [3:0]  en_bus,
  output logic [3:0]  ld,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  halt_code
);

  state_t     state;
  halt_t      halt_q;
  logic [3:0] opcode;
  logic       br_taken;
  logic       in_access;
  logic       timeout;
  logic       unused_ir;

  assign opcode    = IR[15:12];
  assign br_taken  = |(IR[11:9] & nzp);
  assign in_access = (state == FETCH1) || (state == MEMRD) || (state == MEMWR);
  assign unused_ir = ^IR[5:3];
  assign halt_code = halt_q;

  lc3_mem_wait #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_mem_wait (
    .clk      (clk),
    .rst      (rst),
    .active   (in_access),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH0;
      halt_q <= HC_RUN;
    end else begin
      case (state)
        FETCH0: state <= FETCH1;
        FETCH1: begin
          if (mem_ready) begin
            state <= FETCH2;
          end else if (timeout) begin
            state  <= HALT;
            halt_q <= HC_TIMEOUT;
          end
        end
        FETCH2: state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_ADD, OP_AND, OP_NOT:      state <= ALU;
            OP_BR:                       state <= BR;
            OP_JMP:                      state <= JMP;
            OP_LEA:                      state <= LEA;
            OP_LD, OP_ST, OP_LDR, OP_STR: state <= ADDR;
            OP_TRAP: begin
              state  <= HALT;
              halt_q <= HC_TRAP;
            end
            default: begin
              state  <= HALT;
              halt_q <= HC_ILLEGAL;
            end
          endcase
        end
        ADDR:   state <= is_load(opcode) ? MEMRD : STDATA;
        MEMRD: begin
          if (mem_ready) begin
            state <= LDWB;
          end else if (timeout) begin
            state  <= HALT;
            halt_q <= HC_TIMEOUT;
          end
        end
        STDATA: state <= MEMWR;
        MEMWR: begin
          if (mem_ready) begin
            state <= FETCH0;
          end else if (timeout) begin
            state  <= HALT;
            halt_q <= HC_TIMEOUT;
          end
        end
        ALU, BR, JMP, LEA, LDWB: state <= FETCH0;
        HALT:    state <= HALT;
        default: state <= FETCH0;
      endcase
    end
  end

  // Controls are decoded from state; reset forces them low without waiting for
  // a clock so an in-flight memory request is withdrawn immediately.
  always_comb begin
    aluControl = ALU_PASS;
    SR1        = '0;
    SR2        = '0;
    DR         = '0;
    logicWE    = 1'b0;
    flagWE     = 1'b0;
    selPC      = PC_INC;
    selMAR     = 1'b0;
    selEAB1    = 1'b0;
    selMDR     = 1'b0;
    selEAB2    = EAB2_ZERO;
    en_bus     = '0;
    ld         = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    if (!rst) begin
      case (state)
        FETCH0: begin
          en_bus[EN_PC] = 1'b1;
          ld[LD_MAR]    = 1'b1;
          ld[LD_PC]     = 1'b1;
          selPC         = PC_INC;
        end
        FETCH1, MEMRD: begin
          mem_en     = 1'b1;
          selMDR     = 1'b1;
          ld[LD_MDR] = mem_ready;
        end
        FETCH2: begin
          en_bus[EN_MDR] = 1'b1;
          ld[LD_IR]      = 1'b1;
        end
        ALU: begin
          DR             = IR[11:9];
          SR1            = IR[8:6];
          SR2            = IR[2:0];
          en_bus[EN_ALU] = 1'b1;
          logicWE        = 1'b1;
          flagWE         = 1'b1;
          aluControl     = alu_op_of(opcode);
        end
        BR: begin
          if (br_taken) begin
            ld[LD_PC] = 1'b1;
            selPC     = PC_ADDER;
            selEAB1   = 1'b0;
            selEAB2   = EAB2_OFF9;
          end
        end
        JMP: begin
          SR1       = IR[8:6];
          selEAB1   = 1'b1;
          selEAB2   = EAB2_ZERO;
          selPC     = PC_ADDER;
          ld[LD_PC] = 1'b1;
        end
        LEA: begin
          en_bus[EN_MARM] = 1'b1;
          selMAR          = 1'b0;
          selEAB1         = 1'b0;
          selEAB2         = EAB2_OFF9;
          DR              = IR[11:9];
          logicWE         = 1'b1;
          flagWE          = 1'b1;
        end
        ADDR: begin
          en_bus[EN_MARM] = 1'b1;
          selMAR          = 1'b0;
          ld[LD_MAR]      = 1'b1;
          if (uses_base_reg(opcode)) begin
            selEAB1 = 1'b1;
            SR1     = IR[8:6];
            selEAB2 = EAB2_OFF6;
          end else begin
            selEAB1 = 1'b0;
            selEAB2 = EAB2_OFF9;
          end
        end
        LDWB: begin
          en_bus[EN_MDR] = 1'b1;
          DR             = IR[11:9];
          logicWE        = 1'b1;
          flagWE         = 1'b1;
        end
        STDATA: begin
          SR1            = IR[11:9];
          aluControl     = ALU_PASS;
          en_bus[EN_ALU] = 1'b1;
          ld[LD_MDR]     = 1'b1;
          selMDR         = 1'b0;
        end
        MEMWR: begin
          mem_en = 1'b1;
          mem_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_controller.sv
// Self-checking bench for lc3_controller: per-instruction observations are
// compared against a behavioural model of latency and control events.
module tb_lc3_controller;

  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] IR = '0;
  logic [2:0]  nzp = '0;
  logic        mem_ready = 1'b0;
  logic [1:0]  aluControl;
  logic [2:0]  SR1, SR2, DR;
  logic        logicWE, flagWE;
  logic [1:0]  selPC;
  logic        selMAR, selEAB1, selMDR;
  logic [1:0]  selEAB2;
  logic [3:0]  en_bus, ld;
  logic        mem_en, mem_we;
  logic [1:0]  halt_code;
  logic [29:0] ctl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lc3_controller #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .rst(rst), .IR(IR), .nzp(nzp), .mem_ready(mem_ready),
    .aluControl(aluControl), .SR1(SR1), .SR2(SR2), .DR(DR),
    .logicWE(logicWE), .flagWE(flagWE), .selPC(selPC), .selMAR(selMAR),
    .selEAB1(selEAB1), .selMDR(selMDR), .selEAB2(selEAB2), .en_bus(en_bus),
    .ld(ld), .mem_en(mem_en), .mem_we(mem_we), .halt_code(halt_code)
  );

  assign ctl = {aluControl, SR1, SR2, DR, logicWE, flagWE, selPC, selMAR, selEAB1,
                selMDR, selEAB2, en_bus, ld, mem_en, mem_we};

  always @(negedge clk) begin
    if (!rst) begin
      total++;
      assert ($countones(en_bus) <= 1)
      else begin
        $display("FAIL en_bus_onehot got=%b want=at most one bit", en_bus);
        bad++;
      end
    end
  end

  typedef struct {
    int len; int halt_cyc; int hc;
    int memen_n; int we_n; int mdr_n;
    int wr_n; int wr_dr; int wr_alu;
    int pc_n; int pc_eab2; int pc_eab1;
    int addr_n; int addr_eab2; int addr_eab1;
  } res_t;

  // Expected behaviour of one instruction from FETCH0 until the next FETCH0 (or halt).
  function automatic res_t model(input logic [15:0] ir, input logic [2:0] f,
                                 input int fw, input int dw);
    res_t e;
    logic [3:0] op;
    int dcyc;
    e = '{default: 0};
    op = ir[15:12];
    if (fw > MAXW) begin
      e.memen_n = MAXW + 1; e.hc = 3; e.halt_cyc = MAXW + 3;
      return e;
    end
    e.memen_n = fw + 1;
    e.mdr_n = 1;
    dcyc = (dw > MAXW) ? MAXW + 1 : dw + 1;
    case (op)
      4'h1, 4'h5, 4'h9: begin
        e.len = fw + 5; e.wr_n = 1; e.wr_dr = int'(ir[11:9]);
        e.wr_alu = (op == 4'h1) ? 1 : (op == 4'h5) ? 2 : 3;
      end
      4'h0: begin
        e.len = fw + 5;
        if ((ir[11:9] & f) != 3'b000) begin e.pc_n = 1; e.pc_eab2 = 2; e.pc_eab1 = 0; end
      end
      4'hC: begin e.len = fw + 5; e.pc_n = 1; e.pc_eab2 = 0; e.pc_eab1 = 1; end
      4'hE: begin e.len = fw + 5; e.wr_n = 1; e.wr_dr = int'(ir[11:9]); end
      4'h2, 4'h3, 4'h6, 4'h7: begin
        bit store, base;
        store = (op == 4'h3) || (op == 4'h7);
        base  = (op == 4'h6) || (op == 4'h7);
        e.addr_n = 1; e.addr_eab1 = base ? 1 : 0; e.addr_eab2 = base ? 1 : 2;
        e.memen_n += dcyc;
        if (store) begin e.we_n = dcyc; e.mdr_n = 2; end
        if (dw > MAXW) begin
          e.hc = 3; e.halt_cyc = fw + MAXW + (store ? 8 : 7);
        end else begin
          e.len = fw + dw + 7;
          if (!store) begin e.wr_n = 1; e.wr_dr = int'(ir[11:9]); e.mdr_n = 2; end
        end
      end
      4'hF:    begin e.hc = 1; e.halt_cyc = fw + 5; end
      default: begin e.hc = 2; e.halt_cyc = fw + 5; end
    endcase
    return e;
  endfunction

  // Entered and left at a negedge with the DUT in FETCH0.
  task automatic exec(input logic [15:0] ir, input logic [2:0] f, input int fw,
                      input int dw, input string tag, output bit halted);
    res_t e, o;
    int w[2];
    int cyc, acc, idx, early, flagbad, wr_cyc;
    bit done;
    e = model(ir, f, fw, dw);
    o = '{default: 0};
    IR = ir; nzp = f;
    w[0] = (fw > MAXW) ? 1000 : fw;
    w[1] = (dw > MAXW) ? 1000 : dw;
    acc = 0; idx = 0; mem_ready = 1'b0;
    cyc = 1; done = 0; early = 0; flagbad = 0; wr_cyc = 0;
    for (int k = 0; k < 120 && !done; k++) begin
      if (cyc > 1 && en_bus == 4'b0100 && ld == 4'b1010) begin
        o.len = cyc - 1; done = 1;
      end else if (halt_code != 2'b00) begin
        o.hc = int'(halt_code); o.halt_cyc = cyc; done = 1;
      end else begin
        if (mem_en) o.memen_n++;
        if (mem_we) o.we_n++;
        if (ld[0]) begin
          o.mdr_n++;
          if (mem_en && !mem_ready) early++;
        end
        if (logicWE) begin
          o.wr_n++; o.wr_dr = int'(DR); o.wr_alu = int'(aluControl); wr_cyc = cyc;
        end
        if (logicWE != flagWE) flagbad++;
        if (ld[3] && selPC == 2'b01) begin
          o.pc_n++; o.pc_eab2 = int'(selEAB2); o.pc_eab1 = int'(selEAB1);
        end
        if (en_bus == 4'b1000 && ld == 4'b0010) begin
          o.addr_n++; o.addr_eab2 = int'(selEAB2); o.addr_eab1 = int'(selEAB1);
        end
        @(posedge clk); #1;
        if (mem_en) begin
          acc++; mem_ready = (acc > w[idx]);
        end else begin
          if (acc > 0) idx = 1;
          acc = 0; mem_ready = 1'b0;
        end
        @(negedge clk); cyc++;
      end
    end
    mem_ready = 1'b0;
    halted = (o.hc != 0);
    total++;
    if (!done) begin
      $display("FAIL %s bound got=no fetch0/halt want=end within 120 cycles", tag); bad++;
    end
    total++;
    if (o.hc !== e.hc) begin $display("FAIL %s halt_code got=%0d want=%0d", tag, o.hc, e.hc); bad++; end
    total++;
    if (e.hc == 0 && o.len !== e.len) begin
      $display("FAIL %s latency got=%0d want=%0d", tag, o.len, e.len); bad++;
    end else if (e.hc != 0 && o.halt_cyc !== e.halt_cyc) begin
      $display("FAIL %s halt_cycle got=%0d want=%0d", tag, o.halt_cyc, e.halt_cyc); bad++;
    end
    total++;
    if (o.memen_n !== e.memen_n) begin $display("FAIL %s mem_en_cycles got=%0d want=%0d", tag, o.memen_n, e.memen_n); bad++; end
    total++;
    if (o.we_n !== e.we_n) begin $display("FAIL %s mem_we_cycles got=%0d want=%0d", tag, o.we_n, e.we_n); bad++; end
    total++;
    if (o.mdr_n !== e.mdr_n) begin $display("FAIL %s ldMDR_cycles got=%0d want=%0d", tag, o.mdr_n, e.mdr_n); bad++; end
    total++;
    if (early !== 0) begin $display("FAIL %s ldMDR_without_ready got=%0d want=0", tag, early); bad++; end
    total++;
    if (flagbad !== 0) begin $display("FAIL %s flagWE_vs_logicWE got=%0d want=0", tag, flagbad); bad++; end
    total++;
    if (o.wr_n !== e.wr_n) begin $display("FAIL %s writebacks got=%0d want=%0d", tag, o.wr_n, e.wr_n); bad++; end
    if (e.wr_n == 1 && o.wr_n == 1) begin
      total++;
      if (o.wr_dr !== e.wr_dr || o.wr_alu !== e.wr_alu || wr_cyc !== e.len) begin
        $display("FAIL %s writeback got=DR%0d alu%0d cyc%0d want=DR%0d alu%0d cyc%0d",
                 tag, o.wr_dr, o.wr_alu, wr_cyc, e.wr_dr, e.wr_alu, e.len);
        bad++;
      end
    end
    total++;
    if (o.pc_n !== e.pc_n) begin $display("FAIL %s pc_adder_loads got=%0d want=%0d", tag, o.pc_n, e.pc_n); bad++; end
    if (e.pc_n == 1 && o.pc_n == 1) begin
      total++;
      if (o.pc_eab2 !== e.pc_eab2 || o.pc_eab1 !== e.pc_eab1) begin
        $display("FAIL %s pc_target_sel got=eab1 %0d eab2 %0d want=eab1 %0d eab2 %0d",
                 tag, o.pc_eab1, o.pc_eab2, e.pc_eab1, e.pc_eab2);
        bad++;
      end
    end
    total++;
    if (o.addr_n !== e.addr_n) begin $display("FAIL %s addr_cycles got=%0d want=%0d", tag, o.addr_n, e.addr_n); bad++; end
    if (e.addr_n == 1 && o.addr_n == 1) begin
      total++;
      if (o.addr_eab2 !== e.addr_eab2 || o.addr_eab1 !== e.addr_eab1) begin
        $display("FAIL %s addr_sel got=eab1 %0d eab2 %0d want=eab1 %0d eab2 %0d",
                 tag, o.addr_eab1, o.addr_eab2, e.addr_eab1, e.addr_eab2);
        bad++;
      end
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; mem_ready = 1'b0;
    #2;
    total++;
    if (ctl !== '0 || halt_code !== 2'b00) begin
      $display("FAIL %s reset_outputs got=ctl %h hc %b want=ctl 0 hc 00", tag, ctl, halt_code); bad++;
    end
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if (en_bus !== 4'b0100 || ld !== 4'b1010 || mem_en !== 1'b0 || selPC !== 2'b00) begin
      $display("FAIL %s fetch0_after_reset got=en %b ld %b mem_en %b want=en 0100 ld 1010 mem_en 0",
               tag, en_bus, ld, mem_en);
      bad++;
    end
  endtask

  task automatic check_halt_hold(input logic [1:0] hc, input string tag);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (ctl !== '0 || halt_code !== hc) begin
        $display("FAIL %s halt_hold got=ctl %h hc %b want=ctl 0 hc %b", tag, ctl, halt_code, hc); bad++;
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_add();
    bit h;
    exec(16'h1261, 3'b000, 0, 0, "add_r1", h);
  endtask

  task automatic test_branch();
    bit h;
    exec(16'h0402, 3'b010, 0, 0, "brz_taken", h);
    exec(16'h0402, 3'b100, 0, 0, "brz_not_taken", h);
    exec(16'hC1C0, 3'b000, 1, 0, "jmp", h);
  endtask

  task automatic test_mem_wait();
    bit h;
    exec(16'h2405, 3'b000, 0, 3, "ld_wait3", h);
    exec(16'h7A8F, 3'b000, 2, 2, "str_wait2", h);
  endtask

  task automatic test_timeout();
    bit h;
    exec(16'h1261, 3'b000, 20, 0, "fetch_timeout", h);
    check_halt_hold(2'b11, "fetch_timeout");
    do_reset("after_fetch_timeout");
    exec(16'h3200, 3'b000, 0, 20, "store_timeout", h);
    check_halt_hold(2'b11, "store_timeout");
    do_reset("after_store_timeout");
  endtask

  task automatic test_halt_codes();
    bit h;
    exec(16'hD000, 3'b000, 0, 0, "illegal", h);
    check_halt_hold(2'b10, "illegal");
    do_reset("after_illegal");
    exec(16'hF025, 3'b000, 0, 0, "trap", h);
    check_halt_hold(2'b01, "trap");
    do_reset("after_trap");
  endtask

  task automatic test_reset_memwr();
    bit found;
    found = 0;
    IR = 16'h3E3F; nzp = 3'b000;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk); #1 mem_ready = mem_en && !mem_we;
      @(negedge clk);
      if (mem_we) found = 1;
    end
    total++;
    if (!found) begin $display("FAIL reset_memwr reach got=no MEMWR want=MEMWR within 40 cycles"); bad++; end
    #2 rst = 1'b1;
    #1;
    total++;
    if (mem_we !== 1'b0 || mem_en !== 1'b0) begin
      $display("FAIL reset_memwr async_drop got=en %b we %b want=en 0 we 0", mem_en, mem_we); bad++;
    end
    do_reset("reset_memwr");
  endtask

  task automatic test_back_to_back();
    bit h;
    logic [3:0] op;
    logic [15:0] ir;
    logic [2:0] f;
    int fw, dw;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      ir = {op, 12'($urandom)};
      f  = 3'($urandom);
      fw = ($urandom_range(0, 19) == 0) ? 20 : int'($urandom_range(0, 3));
      dw = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      exec(ir, f, fw, dw, $sformatf("rand%0d_ir%h", i, ir), h);
      if (h) do_reset("rand_recover");
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_add();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_halt_codes();
    test_reset_memwr();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
